// File: rtl/frame_vote_pkg.sv
// Shared state encoding, result codes and defaults for the frame vote scheduler.
// The optional per-frame timeout is enabled with FRAME_VOTE_TIMEOUT_EN.
package frame_vote_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_ARM       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COMPARE   = 3'd4,
        ST_REPORT    = 3'd5
    } state_t;

    localparam logic [1:0] COLOR_RED   = 2'd1;
    localparam logic [1:0] COLOR_GREEN = 2'd2;
    localparam logic [1:0] COLOR_BLUE  = 2'd3;

    localparam logic [1:0] FIG_TRIANGLE = 2'd1;
    localparam logic [1:0] FIG_CIRCLE   = 2'd2;
    localparam logic [1:0] FIG_SQUARE   = 2'd3;

    localparam int LAST_ADDR_DEF = 19199;
    localparam int TIMEOUT_W     = 22;

    // Increment that holds at the limit instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] cur, input logic [3:0] lim);
        sat_inc4 = (cur < lim) ? cur + 4'd1 : cur;
    endfunction

endpackage

// File: rtl/vote_tracker.sv
// Holds the candidate frame result and how many consecutive frames matched it.
// Outputs reflect the values this cycle's update leaves in the registers.
module vote_tracker
    import frame_vote_pkg::*;
#(
    parameter int VOTES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] res,
    output logic       agreed,
    output logic [2:0] match_cnt,
    output logic [3:0] stored
);

    logic [2:0] match_cnt_q, match_cnt_d;
    logic [3:0] stored_q, stored_d;

    always_comb begin
        match_cnt_d = match_cnt_q;
        stored_d    = stored_q;
        if (clear) begin
            match_cnt_d = 3'd0;
            stored_d    = 4'd0;
        end else if (load) begin
            // Code 0 is a legitimate vote, so an empty tracker is recognised by the count.
            if (match_cnt_q == 3'd0 || res != stored_q) begin
                stored_d    = res;
                match_cnt_d = 3'd1;
            end else if (match_cnt_q != 3'd7) begin
                match_cnt_d = match_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_q <= 3'd0;
            stored_q    <= 4'd0;
        end else begin
            match_cnt_q <= match_cnt_d;
            stored_q    <= stored_d;
        end
    end

    assign agreed    = load && (match_cnt_d == 3'(VOTES));
    assign match_cnt = match_cnt_d;
    assign stored    = stored_d;

endmodule

// File: rtl/frame_vote_scheduler.sv
// Arms the colour/figure datapath once per captured frame and votes on its results.
// Define FRAME_VOTE_TIMEOUT_EN to bound each frame's wait for proc_done.
module frame_vote_scheduler
    import frame_vote_pkg::*;
#(
    parameter int AW          = 15,
    parameter int LAST_ADDR   = LAST_ADDR_DEF,
    parameter int VOTES       = 3,
    parameter int MAX_FRAMES  = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          regwrite,
    input  logic [AW-1:0] addr_in,
    input  logic          proc_done,
    input  logic [1:0]    color_in,
    input  logic [1:0]    figure_in,
    output logic          init_procesamiento,
    output logic          busy,
    output logic          result_valid,
    output logic [1:0]    color,
    output logic [1:0]    figure,
    output logic          no_consensus,
    output logic          timeout,
    output logic [3:0]    frames_used
);

    state_t     state_q, state_d;
    logic [3:0] frames_used_q, frames_used_d;
    logic       done_prev_q, done_prev_d;
    logic [3:0] frame_res_q, frame_res_d;
    logic       result_valid_q, result_valid_d;
    logic [1:0] color_q, color_d;
    logic [1:0] figure_q, figure_d;
    logic       no_consensus_q, no_consensus_d;

    logic       track_clear;
    logic       track_load;
    logic       agreed;
    logic [2:0] vote_cnt_unused;
    logic [3:0] stored;

`ifdef FRAME_VOTE_TIMEOUT_EN
    logic                 timeout_q, timeout_d;
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
`else
    logic [TIMEOUT_W-1:0] timeout_cfg_unused;
    assign timeout_cfg_unused = TIMEOUT_W'(TIMEOUT_CYC);
`endif

    vote_tracker #(
        .VOTES (VOTES)
    ) u_vote_tracker (
        .clk       (clk),
        .rst       (rst),
        .clear     (track_clear),
        .load      (track_load),
        .res       (frame_res_q),
        .agreed    (agreed),
        .match_cnt (vote_cnt_unused),
        .stored    (stored)
    );

    assign busy = !(state_q == ST_IDLE || state_q == ST_REPORT);

    always_comb begin
        state_d        = state_q;
        frames_used_d  = frames_used_q;
        done_prev_d    = done_prev_q;
        frame_res_d    = frame_res_q;
        result_valid_d = result_valid_q;
        color_d        = color_q;
        figure_d       = figure_q;
        no_consensus_d = no_consensus_q;
        track_clear    = 1'b0;
        track_load     = 1'b0;
`ifdef FRAME_VOTE_TIMEOUT_EN
        timeout_d      = timeout_q;
        to_cnt_d       = to_cnt_q;
`endif

        // Abort overrides every other transition and leaves the reported result alone.
        if (abort && busy) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_REPORT: begin
                    if (start) begin
                        state_d        = ST_SYNC;
                        result_valid_d = 1'b0;
                        no_consensus_d = 1'b0;
                        frames_used_d  = 4'd0;
                        track_clear    = 1'b1;
`ifdef FRAME_VOTE_TIMEOUT_EN
                        timeout_d      = 1'b0;
`endif
                    end
                end
                ST_SYNC: begin
                    if (regwrite && addr_in == AW'(LAST_ADDR)) begin
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    frames_used_d = sat_inc4(frames_used_q, 4'(MAX_FRAMES));
                    done_prev_d   = proc_done;
                    state_d       = ST_WAIT_DONE;
`ifdef FRAME_VOTE_TIMEOUT_EN
                    to_cnt_d      = '0;
`endif
                end
                ST_WAIT_DONE: begin
                    done_prev_d = proc_done;
                    if (proc_done && !done_prev_q) begin
                        frame_res_d = {color_in, figure_in};
                        state_d     = ST_COMPARE;
                    end
`ifdef FRAME_VOTE_TIMEOUT_EN
                    else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                        if (to_cnt_d == TIMEOUT_W'(TIMEOUT_CYC)) begin
                            timeout_d      = 1'b1;
                            no_consensus_d = 1'b0;
                            result_valid_d = 1'b1;
                            color_d        = 2'd0;
                            figure_d       = 2'd0;
                            state_d        = ST_REPORT;
                        end
                    end
`endif
                end
                ST_COMPARE: begin
                    track_load = 1'b1;
                    if (agreed) begin
                        result_valid_d = 1'b1;
                        color_d        = stored[3:2];
                        figure_d       = stored[1:0];
                        state_d        = ST_REPORT;
                    end else if (frames_used_q == 4'(MAX_FRAMES)) begin
                        result_valid_d = 1'b1;
                        no_consensus_d = 1'b1;
                        color_d        = frame_res_q[3:2];
                        figure_d       = frame_res_q[1:0];
                        state_d        = ST_REPORT;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            frames_used_q  <= 4'd0;
            done_prev_q    <= 1'b0;
            frame_res_q    <= 4'd0;
            result_valid_q <= 1'b0;
            color_q        <= 2'd0;
            figure_q       <= 2'd0;
            no_consensus_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            frames_used_q  <= frames_used_d;
            done_prev_q    <= done_prev_d;
            frame_res_q    <= frame_res_d;
            result_valid_q <= result_valid_d;
            color_q        <= color_d;
            figure_q       <= figure_d;
            no_consensus_q <= no_consensus_d;
        end
    end

`ifdef FRAME_VOTE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            timeout_q <= timeout_d;
            to_cnt_q  <= to_cnt_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign init_procesamiento = (state_q == ST_ARM);
    assign result_valid       = result_valid_q;
    assign color              = color_q;
    assign figure             = figure_q;
    assign no_consensus       = no_consensus_q;
    assign frames_used        = frames_used_q;

endmodule

// File: tb/tb_frame_vote_scheduler.sv
// Directed bench for frame_vote_scheduler (VOTES=3, MAX_FRAMES=8, TIMEOUT_CYC=100).
module tb_frame_vote_scheduler;

    localparam int AW   = 15;
    localparam int LAST = 19199;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          regwrite;
    logic [AW-1:0] addr_in;
    logic          proc_done;
    logic [1:0]    color_in;
    logic [1:0]    figure_in;
    logic          init_procesamiento;
    logic          busy;
    logic          result_valid;
    logic [1:0]    color;
    logic [1:0]    figure;
    logic          no_consensus;
    logic          timeout;
    logic [3:0]    frames_used;

    int n_checks  = 0;
    int n_fail    = 0;
    int init_cnt  = 0;
    int bad_init  = 0;
    int exp_inits = 0;
    logic strobe_prev;

    frame_vote_scheduler #(
        .AW          (AW),
        .LAST_ADDR   (LAST),
        .VOTES       (3),
        .MAX_FRAMES  (8),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .regwrite           (regwrite),
        .addr_in            (addr_in),
        .proc_done          (proc_done),
        .color_in           (color_in),
        .figure_in          (figure_in),
        .init_procesamiento (init_procesamiento),
        .busy               (busy),
        .result_valid       (result_valid),
        .color              (color),
        .figure             (figure),
        .no_consensus       (no_consensus),
        .timeout            (timeout),
        .frames_used        (frames_used)
    );

    always #5 clk = ~clk;

    // Every arm pulse must follow a last-address strobe in the previous cycle.
    always @(posedge clk) begin
        if (init_procesamiento === 1'b1) begin
            init_cnt++;
            if (strobe_prev !== 1'b1) bad_init++;
        end
        strobe_prev <= regwrite && (addr_in == AW'(LAST));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // From SYNC: strobe the last address, see the arm pulse, land in WAIT_DONE.
    task automatic arm();
        regwrite = 1'b1;
        addr_in  = AW'(LAST);
        exp_inits++;
        tick();
        regwrite = 1'b0;
        addr_in  = '0;
        check("init_pulse", 32'(init_procesamiento), 1);
        tick();
        check("init_single", 32'(init_procesamiento), 0);
    endtask

    // From WAIT_DONE: one low cycle, then a done rising edge carrying the result.
    task automatic finish_frame(input logic [1:0] c, input logic [1:0] f);
        proc_done = 1'b0;
        tick();
        proc_done = 1'b1;
        color_in  = c;
        figure_in = f;
        tick();
        proc_done = 1'b0;
        color_in  = 2'd0;
        figure_in = 2'd0;
        tick();
    endtask

    task automatic frame(input logic [1:0] c, input logic [1:0] f);
        arm();
        finish_frame(c, f);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        regwrite  = 1'b0;
        addr_in   = '0;
        proc_done = 1'b0;
        color_in  = 2'd0;
        figure_in = 2'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_color", 32'(color), 0);
        check("rst_figure", 32'(figure), 0);
        check("rst_nocons", 32'(no_consensus), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_frames", 32'(frames_used), 0);
        check("rst_init", 32'(init_procesamiento), 0);

        // Basic consensus: three frames of (green, triangle).
        do_start();
        check("t1_busy", 32'(busy), 1);
        addr_in = AW'(LAST);
        tick();
        check("t1_no_strobe_no_arm", 32'(init_procesamiento), 0);
        regwrite = 1'b1;
        addr_in  = AW'(100);
        tick();
        regwrite = 1'b0;
        addr_in  = '0;
        check("t1_wrong_addr_no_arm", 32'(init_procesamiento), 0);
        frame(2'd2, 2'd1);
        check("t1_f1_frames", 32'(frames_used), 1);
        check("t1_f1_valid", 32'(result_valid), 0);
        frame(2'd2, 2'd1);
        check("t1_f2_valid", 32'(result_valid), 0);
        frame(2'd2, 2'd1);
        check("t1_valid", 32'(result_valid), 1);
        check("t1_color", 32'(color), 2);
        check("t1_figure", 32'(figure), 1);
        check("t1_frames", 32'(frames_used), 3);
        check("t1_nocons", 32'(no_consensus), 0);
        check("t1_busy_done", 32'(busy), 0);

        // Mismatch restarts the vote; start while busy is ignored.
        do_start();
        check("t2_valid_cleared", 32'(result_valid), 0);
        check("t2_frames_cleared", 32'(frames_used), 0);
        frame(2'd1, 2'd3);
        do_start();
        check("t2_start_ignored", 32'(frames_used), 1);
        frame(2'd2, 2'd3);
        frame(2'd2, 2'd3);
        check("t2_f3_valid", 32'(result_valid), 0);
        frame(2'd2, 2'd3);
        check("t2_valid", 32'(result_valid), 1);
        check("t2_color", 32'(color), 2);
        check("t2_figure", 32'(figure), 3);
        check("t2_frames", 32'(frames_used), 4);
        check("t2_nocons", 32'(no_consensus), 0);

        // No consensus: alternating results over all eight frames.
        do_start();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) frame(2'd1, 2'd1);
            else            frame(2'd3, 2'd2);
            if (i == 6) begin
                check("t3_f7_valid", 32'(result_valid), 0);
                check("t3_f7_busy", 32'(busy), 1);
            end
        end
        check("t3_valid", 32'(result_valid), 1);
        check("t3_nocons", 32'(no_consensus), 1);
        check("t3_color", 32'(color), 3);
        check("t3_figure", 32'(figure), 2);
        check("t3_frames", 32'(frames_used), 8);

        // Stale done: a level already high at arm must fall before it counts.
        proc_done = 1'b1;
        do_start();
        check("t4_nocons_cleared", 32'(no_consensus), 0);
        arm();
        color_in  = 2'd1;
        figure_in = 2'd2;
        repeat (3) tick();
        check("t4_still_waiting", 32'(busy), 1);
        check("t4_frames", 32'(frames_used), 1);
        proc_done = 1'b0;
        tick();
        finish_frame(2'd3, 2'd3);
        frame(2'd3, 2'd3);
        check("t4_f2_valid", 32'(result_valid), 0);
        frame(2'd3, 2'd3);
        check("t4_valid", 32'(result_valid), 1);
        check("t4_color", 32'(color), 3);
        check("t4_figure", 32'(figure), 3);
        check("t4_frames_final", 32'(frames_used), 3);

        // Abort in WAIT_DONE, coinciding with a done edge.
        do_start();
        arm();
        abort     = 1'b1;
        proc_done = 1'b1;
        color_in  = 2'd1;
        figure_in = 2'd1;
        tick();
        abort     = 1'b0;
        proc_done = 1'b0;
        color_in  = 2'd0;
        figure_in = 2'd0;
        check("t5_busy", 32'(busy), 0);
        check("t5_valid", 32'(result_valid), 0);
        check("t5_color_kept", 32'(color), 3);
        check("t5_figure_kept", 32'(figure), 3);
        check("t5_frames", 32'(frames_used), 1);
        repeat (2) tick();
        check("t5_idle", 32'(busy), 0);

        // Reset for one cycle in SYNC.
        do_start();
        check("t6_busy", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy_rst", 32'(busy), 0);
        check("t6_color_rst", 32'(color), 0);
        check("t6_figure_rst", 32'(figure), 0);
        check("t6_frames_rst", 32'(frames_used), 0);
        check("t6_valid_rst", 32'(result_valid), 0);
        check("t6_nocons_rst", 32'(no_consensus), 0);
        regwrite = 1'b1;
        addr_in  = AW'(LAST);
        tick();
        regwrite = 1'b0;
        addr_in  = '0;
        check("t6_idle_no_arm", 32'(init_procesamiento), 0);
        tick();
        check("t6_idle", 32'(busy), 0);

`ifdef FRAME_VOTE_TIMEOUT_EN
        // Timeout: proc_done never rises.
        do_start();
        arm();
        repeat (99) tick();
        check("t7_timeout_early", 32'(timeout), 0);
        check("t7_busy_early", 32'(busy), 1);
        tick();
        check("t7_timeout", 32'(timeout), 1);
        check("t7_valid", 32'(result_valid), 1);
        check("t7_color", 32'(color), 0);
        check("t7_figure", 32'(figure), 0);
        check("t7_nocons", 32'(no_consensus), 0);
        check("t7_busy", 32'(busy), 0);
`else
        check("t7_timeout_tied", 32'(timeout), 0);
`endif

        check("init_count", 32'(init_cnt), 32'(exp_inits));
        check("init_aligned", 32'(bad_init), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
